// File: rtl/acc_snap_ctrl_pkg.sv
// Shared types and default sizes for the accumulation-window / snapshot sequencer.
package acc_snap_ctrl_pkg;

  localparam int DEF_LEN_WIDTH       = 32;
  localparam int DEF_CNT_WIDTH       = 32;
  localparam int DEF_SNAP_ADDR_WIDTH = 10;

  typedef enum logic [1:0] {
    SNAP_IDLE    = 2'd0,
    SNAP_ARMED   = 2'd1,
    SNAP_CAPTURE = 2'd2,
    SNAP_DONE    = 2'd3
  } snap_state_t;

endpackage

// File: rtl/acc_snap_ctrl_if.sv
// Register-file controls, sample stream and accumulator/snapshot strobes of acc_snap_ctrl.
// din_valid is a one-way valid with no back-pressure: every cycle it is high, one
// sample is consumed, and dout_valid repeats it exactly one cycle later.
interface acc_snap_ctrl_if
  import acc_snap_ctrl_pkg::*;
#(
  parameter int LEN_WIDTH       = DEF_LEN_WIDTH,
  parameter int CNT_WIDTH       = DEF_CNT_WIDTH,
  parameter int SNAP_ADDR_WIDTH = DEF_SNAP_ADDR_WIDTH
);
  logic [LEN_WIDTH-1:0]       acc_len;
  logic                       cnt_rst;
  logic                       snapshot_trigger;
  logic                       din_valid;
  logic                       dout_valid;
  logic                       acc_first;
  logic                       acc_last;
  logic [CNT_WIDTH-1:0]       dump_count;
  logic                       snap_we;
  logic [SNAP_ADDR_WIDTH-1:0] snap_addr;
  logic                       snap_busy;
  logic                       snap_done;
  snap_state_t                state_dbg;

  modport master (
    output acc_len, cnt_rst, snapshot_trigger, din_valid,
    input  dout_valid, acc_first, acc_last, dump_count, snap_we, snap_addr,
           snap_busy, snap_done, state_dbg
  );

  modport slave (
    input  acc_len, cnt_rst, snapshot_trigger, din_valid,
    output dout_valid, acc_first, acc_last, dump_count, snap_we, snap_addr,
           snap_busy, snap_done, state_dbg
  );
endinterface

// File: rtl/acc_window_cnt.sv
// Window length latch and valid-sample counter; decodes the first/last sample of each window.
module acc_window_cnt
  import acc_snap_ctrl_pkg::*;
#(
  parameter int LEN_WIDTH = DEF_LEN_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din_valid,
  input  logic [LEN_WIDTH-1:0] acc_len,
  input  logic                 clr,
  output logic                 first_c,
  output logic                 last_c
);
  logic [LEN_WIDTH-1:0] len;
  logic [LEN_WIDTH-1:0] smp_cnt;
  logic [LEN_WIDTH-1:0] cur_len;
  logic                 at_start;

  // At a window start the fresh acc_len applies immediately, so len=1 windows
  // decode first and last on the same sample.
  assign at_start = (smp_cnt == '0);
  assign cur_len  = at_start ? ((acc_len == '0) ? LEN_WIDTH'(1) : acc_len) : len;
  assign first_c  = din_valid & at_start;
  assign last_c   = din_valid & (smp_cnt == cur_len - LEN_WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_cnt <= '0;
      len     <= LEN_WIDTH'(1);
    end else if (clr) begin
      smp_cnt <= '0;
    end else if (din_valid) begin
      if (at_start) len <= cur_len;
      smp_cnt <= last_c ? '0 : smp_cnt + LEN_WIDTH'(1);
    end
  end
endmodule

// File: rtl/acc_snap_ctrl.sv
// Accumulation-window and snapshot sequencer: registered accumulator strobes, dump
// counter and the capture FSM that writes consecutive dumps into the snapshot BRAM.
module acc_snap_ctrl
  import acc_snap_ctrl_pkg::*;
#(
  parameter int LEN_WIDTH       = DEF_LEN_WIDTH,
  parameter int CNT_WIDTH       = DEF_CNT_WIDTH,
  parameter int SNAP_ADDR_WIDTH = DEF_SNAP_ADDR_WIDTH
) (
  input  logic           axi_clock,
  input  logic           rst_n,
  acc_snap_ctrl_if.slave bus
);
  logic                       first_c;
  logic                       last_c;
  logic                       trig_q;
  logic                       rise;
  logic [SNAP_ADDR_WIDTH-1:0] wptr;
  snap_state_t                state;

  acc_window_cnt #(.LEN_WIDTH(LEN_WIDTH)) u_window (
    .clk       (axi_clock),
    .rst_n     (rst_n),
    .din_valid (bus.din_valid),
    .acc_len   (bus.acc_len),
    .clr       (bus.cnt_rst),
    .first_c   (first_c),
    .last_c    (last_c)
  );

  assign rise          = bus.snapshot_trigger & ~trig_q;
  assign bus.state_dbg = state;

  // trig_q resets high so a trigger already asserted at reset release never arms.
  always_ff @(posedge axi_clock or negedge rst_n) begin
    if (!rst_n) begin
      trig_q         <= 1'b1;
      state          <= SNAP_IDLE;
      wptr           <= '0;
      bus.dout_valid <= 1'b0;
      bus.acc_first  <= 1'b0;
      bus.acc_last   <= 1'b0;
      bus.dump_count <= '0;
      bus.snap_we    <= 1'b0;
      bus.snap_addr  <= '0;
      bus.snap_busy  <= 1'b0;
      bus.snap_done  <= 1'b0;
    end else begin
      trig_q <= bus.snapshot_trigger;
      if (bus.cnt_rst) begin
        state          <= SNAP_IDLE;
        wptr           <= '0;
        bus.dout_valid <= 1'b0;
        bus.acc_first  <= 1'b0;
        bus.acc_last   <= 1'b0;
        bus.dump_count <= '0;
        bus.snap_we    <= 1'b0;
        bus.snap_addr  <= '0;
        bus.snap_busy  <= 1'b0;
        bus.snap_done  <= 1'b0;
      end else begin
        bus.dout_valid <= bus.din_valid;
        bus.acc_first  <= first_c;
        bus.acc_last   <= last_c;
        bus.snap_we    <= 1'b0;
        if (last_c) bus.dump_count <= bus.dump_count + CNT_WIDTH'(1);
        // Decisions use the state held when the sample arrives, so a dump that
        // coincides with arming is not captured.
        unique case (state)
          SNAP_IDLE, SNAP_DONE: begin
            if (rise) begin
              state         <= SNAP_ARMED;
              bus.snap_busy <= 1'b1;
              bus.snap_done <= 1'b0;
            end
          end
          SNAP_ARMED: begin
            if (last_c) begin
              bus.snap_we   <= 1'b1;
              bus.snap_addr <= '0;
              wptr          <= SNAP_ADDR_WIDTH'(1);
              state         <= SNAP_CAPTURE;
            end
          end
          SNAP_CAPTURE: begin
            if (last_c) begin
              bus.snap_we   <= 1'b1;
              bus.snap_addr <= wptr;
              wptr          <= wptr + SNAP_ADDR_WIDTH'(1);
              if (wptr == '1) begin
                state         <= SNAP_DONE;
                bus.snap_busy <= 1'b0;
                bus.snap_done <= 1'b1;
              end
            end
          end
          default: state <= SNAP_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_acc_snap_ctrl.sv
// Directed table-driven bench for acc_snap_ctrl with a 4-entry snapshot window.
module tb_acc_snap_ctrl;
  import acc_snap_ctrl_pkg::*;

  localparam int LW = 32;
  localparam int CW = 32;
  localparam int AW = 2;

  typedef struct {
    int          ph;
    logic        dv;
    logic [31:0] len;
    logic        crst;
    logic        trig;
    logic [39:0] exp;
  } vec_t;

  logic axi_clock = 1'b0;
  logic rst_n     = 1'b0;
  int   n_vec     = 0;
  int   n_err     = 0;
  vec_t vec_q[$];

  acc_snap_ctrl_if #(.LEN_WIDTH(LW), .CNT_WIDTH(CW), .SNAP_ADDR_WIDTH(AW)) bus ();

  acc_snap_ctrl #(.LEN_WIDTH(LW), .CNT_WIDTH(CW), .SNAP_ADDR_WIDTH(AW)) dut (
    .axi_clock (axi_clock),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  // clock / reset
  always #5 axi_clock = ~axi_clock;

  // Output packing: {dout_valid, first, last, we, busy, done, addr[1:0], count[31:0]}
  function automatic logic [39:0] actual();
    return {bus.dout_valid, bus.acc_first, bus.acc_last, bus.snap_we,
            bus.snap_busy, bus.snap_done, bus.snap_addr, bus.dump_count};
  endfunction

  function automatic vec_t mk(int ph, bit dv, int len, bit crst, bit trig,
                              bit fv, bit ff, bit fl, bit we, bit busy, bit done,
                              int addr, int cnt);
    vec_t v;
    v.ph   = ph;
    v.dv   = dv;
    v.len  = 32'(len);
    v.crst = crst;
    v.trig = trig;
    v.exp  = {fv, ff, fl, we, busy, done, 2'(addr), 32'(cnt)};
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.din_valid        = v.dv;
    bus.acc_len          = v.len;
    bus.cnt_rst          = v.crst;
    bus.snapshot_trigger = v.trig;
  endtask

  task automatic check(input string name, input logic [39:0] exp);
    logic [39:0] act;
    act = actual();
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got fv/ff/fl/we/busy/done=%b addr=%0d cnt=%0d, want %b addr=%0d cnt=%0d",
               name, act[39:34], act[33:32], act[31:0], exp[39:34], exp[33:32], exp[31:0]);
    end
  endtask

  // Drive one vector after a rising edge, check its registered result after the next.
  task automatic run_queue();
    for (int i = 0; i < vec_q.size(); i++) begin
      drive(vec_q[i]);
      @(posedge axi_clock);
      #1;
      check($sformatf("ph%0d_vec%0d", vec_q[i].ph, i), vec_q[i].exp);
    end
    vec_q.delete();
  endtask

  initial begin
    bus.din_valid        = 1'b0;
    bus.acc_len          = 32'd4;
    bus.cnt_rst          = 1'b0;
    bus.snapshot_trigger = 1'b0;
    repeat (3) @(posedge axi_clock);
    #1 rst_n = 1'b1;
    @(posedge axi_clock);
    #1;
    check("reset_outputs", 40'd0);

    // len=4, 12 back-to-back samples
    for (int i = 0; i < 12; i++)
      vec_q.push_back(mk(1, 1, 4, 0, 0, 1, (i % 4) == 0, (i % 4) == 3, 0, 0, 0, 0,
                         i / 4 + int'((i % 4) == 3)));
    vec_q.push_back(mk(1, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    // len=0 and len=1: every sample is both first and last
    for (int i = 0; i < 3; i++) vec_q.push_back(mk(2, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 4 + i));
    for (int i = 0; i < 2; i++) vec_q.push_back(mk(2, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 7 + i));
    // len=3 with a gap after every sample
    for (int k = 0; k < 6; k++) begin
      vec_q.push_back(mk(3, 1, 3, 0, 0, 1, (k % 3) == 0, (k % 3) == 2, 0, 0, 0, 0,
                         8 + k / 3 + int'((k % 3) == 2)));
      vec_q.push_back(mk(3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8 + (k + 1) / 3));
    end
    // len 4 -> 2 after the second sample of a window
    vec_q.push_back(mk(4, 1, 4, 0, 0, 1, 1, 0, 0, 0, 0, 0, 10));
    vec_q.push_back(mk(4, 1, 4, 0, 0, 1, 0, 0, 0, 0, 0, 0, 10));
    vec_q.push_back(mk(4, 1, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0, 10));
    vec_q.push_back(mk(4, 1, 2, 0, 0, 1, 0, 1, 0, 0, 0, 0, 11));
    vec_q.push_back(mk(4, 1, 2, 0, 0, 1, 1, 0, 0, 0, 0, 0, 11));
    vec_q.push_back(mk(4, 1, 2, 0, 0, 1, 0, 1, 0, 0, 0, 0, 12));
    vec_q.push_back(mk(4, 1, 2, 0, 0, 1, 1, 0, 0, 0, 0, 0, 12));
    vec_q.push_back(mk(4, 1, 2, 0, 0, 1, 0, 1, 0, 0, 0, 0, 13));
    // trigger pulse, four captures, then DONE ignores further dumps
    vec_q.push_back(mk(5, 0, 2, 0, 1, 0, 0, 0, 0, 1, 0, 0, 13));
    vec_q.push_back(mk(5, 1, 2, 0, 0, 1, 1, 0, 0, 1, 0, 0, 13));
    vec_q.push_back(mk(5, 1, 2, 0, 0, 1, 0, 1, 1, 1, 0, 0, 14));
    vec_q.push_back(mk(5, 1, 2, 0, 0, 1, 1, 0, 0, 1, 0, 0, 14));
    vec_q.push_back(mk(5, 1, 2, 0, 0, 1, 0, 1, 1, 1, 0, 1, 15));
    vec_q.push_back(mk(5, 1, 2, 0, 0, 1, 1, 0, 0, 1, 0, 1, 15));
    vec_q.push_back(mk(5, 1, 2, 0, 0, 1, 0, 1, 1, 1, 0, 2, 16));
    vec_q.push_back(mk(5, 1, 2, 0, 0, 1, 1, 0, 0, 1, 0, 2, 16));
    vec_q.push_back(mk(5, 1, 2, 0, 0, 1, 0, 1, 1, 0, 1, 3, 17));
    vec_q.push_back(mk(5, 1, 2, 0, 0, 1, 1, 0, 0, 0, 1, 3, 17));
    vec_q.push_back(mk(5, 1, 2, 0, 0, 1, 0, 1, 0, 0, 1, 3, 18));
    // second trigger re-arms and captures from address 0
    vec_q.push_back(mk(6, 0, 2, 0, 1, 0, 0, 0, 0, 1, 0, 3, 18));
    vec_q.push_back(mk(6, 1, 2, 0, 0, 1, 1, 0, 0, 1, 0, 3, 18));
    vec_q.push_back(mk(6, 1, 2, 0, 0, 1, 0, 1, 1, 1, 0, 0, 19));
    vec_q.push_back(mk(6, 1, 2, 0, 0, 1, 1, 0, 0, 1, 0, 0, 19));
    vec_q.push_back(mk(6, 1, 2, 0, 0, 1, 0, 1, 1, 1, 0, 1, 20));
    vec_q.push_back(mk(6, 1, 2, 0, 0, 1, 1, 0, 0, 1, 0, 1, 20));
    // cnt_rst mid-window during capture; trigger rising under cnt_rst must not arm
    vec_q.push_back(mk(7, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vec_q.push_back(mk(7, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vec_q.push_back(mk(7, 1, 2, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0));
    vec_q.push_back(mk(7, 1, 2, 0, 1, 1, 0, 1, 0, 0, 0, 0, 1));
    vec_q.push_back(mk(7, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vec_q.push_back(mk(7, 1, 2, 0, 1, 1, 1, 0, 0, 1, 0, 0, 1));
    vec_q.push_back(mk(7, 1, 2, 0, 1, 1, 0, 1, 1, 1, 0, 0, 2));
    run_queue();

    // Asynchronous reset mid-capture, trigger held high throughout
    bus.din_valid        = 1'b1;
    bus.acc_len          = 32'd2;
    bus.cnt_rst          = 1'b0;
    bus.snapshot_trigger = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 40'd0);
    n_vec++;
    if (bus.state_dbg !== SNAP_IDLE) begin
      n_err++;
      $display("FAIL async_reset_state: got %0d want %0d", bus.state_dbg, SNAP_IDLE);
    end
    @(posedge axi_clock);
    #1 rst_n = 1'b1;

    // Held-high trigger must not arm; a rise coinciding with an IDLE dump arms without capturing it
    vec_q.push_back(mk(8, 1, 2, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0));
    vec_q.push_back(mk(8, 1, 2, 0, 1, 1, 0, 1, 0, 0, 0, 0, 1));
    vec_q.push_back(mk(8, 1, 2, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1));
    vec_q.push_back(mk(8, 1, 2, 0, 1, 1, 0, 1, 0, 1, 0, 0, 2));
    vec_q.push_back(mk(8, 1, 2, 0, 1, 1, 1, 0, 0, 1, 0, 0, 2));
    vec_q.push_back(mk(8, 1, 2, 0, 1, 1, 0, 1, 1, 1, 0, 0, 3));
    run_queue();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/acc_snap_ctrl.md
# acc_snap_ctrl

Accumulation-window and snapshot sequencer for the single-bin DFT correlator. It turns the register-file controls `acc_len`, `cnt_rst` and `snapshot_trigger` into per-sample `acc_first`/`acc_last` strobes for the accumulator, plus a dump counter. It also generates write strobes and addresses that capture a fixed number of consecutive accumulator dumps into the snapshot BRAM. It sits between the AXI-Lite register block and the accumulator/snapshot datapath, all in the `axi_clock` domain.

## Interface
Parameters:
- `LEN_WIDTH`, 32: width of `acc_len`.
- `CNT_WIDTH`, 32: width of `dump_count`.
- `SNAP_ADDR_WIDTH`, 10: snapshot depth is 2**SNAP_ADDR_WIDTH dumps.

Ports:
- `axi_clock`, in, 1: single clock. All logic is on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `acc_len`, in, LEN_WIDTH: valid samples per window. 0 is treated as 1.
- `cnt_rst`, in, 1: level. While high, the block holds its counters and snapshot FSM in reset.
- `snapshot_trigger`, in, 1: level. A rising edge arms a capture.
- `din_valid`, in, 1: DFT output sample valid.
- `dout_valid`, out, 1: `din_valid` delayed by 1 cycle.
- `acc_first`, out, 1: marks the first sample of a window, aligned with `dout_valid`.
- `acc_last`, out, 1: marks the last sample of a window (the dump), aligned with `dout_valid`.
- `dump_count`, out, CNT_WIDTH: number of windows completed since the last reset or `cnt_rst`. Wraps.
- `snap_we`, out, 1: snapshot BRAM write strobe, coincident with `acc_last`.
- `snap_addr`, out, SNAP_ADDR_WIDTH: snapshot BRAM write address.
- `snap_busy`, out, 1: high in ARMED or CAPTURE.
- `snap_done`, out, 1: high in DONE.

## Operation
- Window counter `smp_cnt` (LEN_WIDTH bits) counts valid samples from 0 to len−1.
- `len` is latched from `acc_len` on the valid sample where `smp_cnt`==0. The value 0 is mapped to 1. A change to `acc_len` mid-window takes effect at the next window.
- First: `din_valid` & `smp_cnt`==0.
- Last: `din_valid` & `smp_cnt`==len−1. On last, `smp_cnt` goes to 0. When len=1, first and last are both set on every sample.
- On every last, `dump_count` increments (modulo 2**CNT_WIDTH).
- Rising-edge detect: `rise` = `snapshot_trigger` & ~`trig_q`.
- Snapshot FSM (states in package):
  - IDLE: on `rise`, go to ARMED.
  - ARMED: on last, write address 0, set `wptr`=1, go to CAPTURE.
  - CAPTURE: on last, write address `wptr` and increment it. The write to address 2**SNAP_ADDR_WIDTH−1 moves the FSM to DONE.
  - DONE: on `rise`, go to ARMED.
- `rise` is ignored in ARMED and CAPTURE.
- `cnt_rst` high, checked each cycle, has priority over everything:
  - `smp_cnt`=0, `dump_count`=0, FSM=IDLE, `wptr`=0.
  - `dout_valid`, `acc_first`, `acc_last` and `snap_we` are 0 in the following cycle.
  - Any partial window is discarded.
  - After `cnt_rst` falls, the next valid sample is a first.
  - `trig_q` keeps tracking the trigger during `cnt_rst`.

## Timing
- Latency is 1 cycle from `din_valid` to `dout_valid`, `acc_first`, `acc_last` and `snap_we`. Every output is registered.
- Throughput is 1 sample per cycle. Gaps in `din_valid` simply pause the window.
- `dump_count` and `snap_addr` update on the same edge that raises `acc_last`. While `acc_last`=1, `dump_count` includes the current dump.
- The FSM state used for the decision is the state at the cycle `din_valid` is sampled. Consequences:
  - A `rise` in the same cycle as a last while in IDLE arms the FSM, but that dump is not captured.
  - The DONE transition occurs on the same edge as the final `snap_we`.
- Reset values:
  - All outputs are 0 and the FSM is IDLE.
  - `smp_cnt`=0, `len`=1, `wptr`=0.
  - `trig_q` resets to 1, so a trigger already high at reset release does not arm. It needs a fresh low→high edge.
- An asynchronous reset mid-window or mid-capture immediately forces the reset values above.

## Structure
- Package `acc_snap_ctrl_pkg` holds:
  - `snap_state_t` (SNAP_IDLE, SNAP_ARMED, SNAP_CAPTURE, SNAP_DONE).
  - Default parameter constants.
- One sub-module, `acc_window_cnt`, contains the len latch, the `smp_cnt` counter and the first/last decode. It has inputs `din_valid`, `acc_len`, `clr` and outputs `first_c`, `last_c`.
- The top level holds the output registers, `dump_count`, the edge detect and the snapshot FSM.

## Test plan
- `acc_len`=4, `din_valid` high for 12 cycles:
  - `acc_first` on samples 0, 4, 8 (1 cycle late).
  - `acc_last` on samples 3, 7, 11.
  - `dump_count` reads 1, 2, 3 at each `acc_last`.
- `acc_len`=0, then 1: `acc_first` and `acc_last` on every valid sample. `acc_len`=3 with `din_valid` every other cycle: `acc_last` on every 3rd valid sample, never on an idle cycle.
- `acc_len` changed 4→2 after the 2nd sample of a window: the current window still ends at its 4th sample, and subsequent windows are 2 samples.
- `SNAP_ADDR_WIDTH`=2, `acc_len`=2, trigger pulse:
  - `snap_busy`=1 until DONE.
  - `snap_we` on the next 4 `acc_last` with `snap_addr` 0, 1, 2, 3.
  - `snap_done`=1 after that; further dumps produce no `snap_we`.
  - A second trigger edge clears `snap_done` and captures again from address 0.
- `cnt_rst` pulsed mid-window during CAPTURE:
  - `dump_count`=0, FSM IDLE, `snap_busy`=`snap_done`=0, no strobes while it is high.
  - After release, the first valid sample gives `acc_first`=1.
- `rst_n` pulsed low mid-capture with `snapshot_trigger` held high:
  - All outputs go to 0 immediately.
  - No arming until the trigger goes low and then high again.
